// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter family: state encoding,
// default pattern and idle level, plus the parity helper used when SEQ_TX_PARITY_EN is set.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } state_t;

  localparam logic [3:0] PAT_0110     = 4'b0110;
  localparam logic       IDLE_LVL_DEF = 1'b1;

  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/seq_shift_out.sv
// Pattern bit selector with a down-counting index of the bit currently on the line.
// bit_sel is the value the top should register on this edge (MSB on load, next bit on advance).
module seq_shift_out
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_0110
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic bit_sel,
  output logic last_bit
);

  localparam int             IW      = $clog2(PAT_W);
  localparam logic [IW-1:0]  TOP_IDX = IW'(PAT_W - 1);

  logic [IW-1:0] bit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (load) begin
      bit_idx <= TOP_IDX;
    end else if (advance) begin
      bit_idx <= bit_idx - 1'b1;
    end
  end

  assign last_bit = (bit_idx == '0);
  assign bit_sel  = load ? PATTERN[PAT_W-1] : PATTERN[bit_idx - 1'b1];

endmodule

// File: rtl/seq_tx_0110.sv
// Serial pattern transmitter: emits PATTERN MSB-first rep_cnt times with GAP idle bits between.
// Optional macro SEQ_TX_PARITY_EN appends an even-parity bit after every repetition.
module seq_tx_0110
  import seq_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = PAT_0110,
  parameter int               CNT_W    = 4,
  parameter int               GAP      = 2,
  parameter logic             IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  // A one-bit gap counter is kept even for GAP=0 so the datapath stays well-formed.
  localparam int            GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  state_t           state, state_d;
  logic             out_d, valid_d;
  logic [CNT_W-1:0] reps_left, reps_d;
  logic [GW-1:0]    gap_cnt, gap_d;
  logic             load, advance, bit_sel, last_bit;

`ifdef SEQ_TX_PARITY_EN
  localparam logic PAR_BIT = even_parity(32'(PATTERN));
  logic par_phase, par_phase_d;
`endif

  seq_shift_out #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .bit_sel (bit_sel),
    .last_bit(last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out       <= IDLE_LVL;
      out_valid <= 1'b0;
      reps_left <= '0;
      gap_cnt   <= '0;
`ifdef SEQ_TX_PARITY_EN
      par_phase <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      out       <= out_d;
      out_valid <= valid_d;
      reps_left <= reps_d;
      gap_cnt   <= gap_d;
`ifdef SEQ_TX_PARITY_EN
      par_phase <= par_phase_d;
`endif
    end
  end

  // reps_left counts repetitions still to start, so it decrements at each repetition's MSB.
  always_comb begin
    state_d = state;
    out_d   = IDLE_LVL;
    valid_d = 1'b0;
    reps_d  = reps_left;
    gap_d   = gap_cnt;
    load    = 1'b0;
    advance = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    par_phase_d = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start_valid) begin
          if (rep_cnt != '0) begin
            load    = 1'b1;
            out_d   = bit_sel;
            valid_d = 1'b1;
            reps_d  = rep_cnt - 1'b1;
            state_d = ST_SEND;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!last_bit) begin
          advance = 1'b1;
          out_d   = bit_sel;
          valid_d = 1'b1;
        end
`ifdef SEQ_TX_PARITY_EN
        else if (!par_phase) begin
          out_d       = PAR_BIT;
          valid_d     = 1'b1;
          par_phase_d = 1'b1;
        end
`endif
        else if (reps_left == '0) begin
          state_d = ST_FIN;
        end else if (GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          load    = 1'b1;
          out_d   = bit_sel;
          valid_d = 1'b1;
          reps_d  = reps_left - 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt <= GW'(1)) begin
          load    = 1'b1;
          out_d   = bit_sel;
          valid_d = 1'b1;
          reps_d  = reps_left - 1'b1;
          state_d = ST_SEND;
        end else begin
          gap_d = gap_cnt - 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FIN);

endmodule

// File: tb/tb_seq_tx_0110.sv
// Self-checking bench for seq_tx_0110: one instance with GAP=2, one with GAP=0,
// checked cycle by cycle against a waveform built from the burst rules.
module tb_seq_tx_0110;

  localparam int PAT_W = 4;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       sv_a, ab_a, sv_b, ab_b;
  logic [3:0] rc_a, rc_b;
  logic       rdy_a, out_a, ov_a, busy_a, done_a;
  logic       rdy_b, out_b, ov_b, busy_b, done_b;

  int vectors    = 0;
  int miscompares = 0;
  int sel        = 0;
  int r, ab, len;
  int det_n, det_hits;
  logic [3:0] det_sr;

  typedef struct packed {
    logic o;
    logic v;
    logic d;
  } step_t;
  step_t expq[$];

  always #5 clk = ~clk;

  seq_tx_0110 #(.PAT_W(4), .PATTERN(4'b0110), .CNT_W(4), .GAP(GAP_A), .IDLE_LVL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start_valid(sv_a), .start_ready(rdy_a), .rep_cnt(rc_a),
    .abort(ab_a), .out(out_a), .out_valid(ov_a), .busy(busy_a), .done(done_a)
  );

  seq_tx_0110 #(.PAT_W(4), .PATTERN(4'b0110), .CNT_W(4), .GAP(GAP_B), .IDLE_LVL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start_valid(sv_b), .start_ready(rdy_b), .rep_cnt(rc_b),
    .abort(ab_b), .out(out_b), .out_valid(ov_b), .busy(busy_b), .done(done_b)
  );

  function automatic int parityBits();
    int p = 0;
`ifdef SEQ_TX_PARITY_EN
    p = 1;
`endif
    return p;
  endfunction

  function automatic int burstLen(input int reps, input int gap);
    if (reps == 0) return 1;
    return reps * (PAT_W + parityBits()) + (reps - 1) * gap + 1;
  endfunction

  // Expected line per cycle after the accepting edge, ending with the done cycle.
  function automatic void buildBurst(input int reps, input int gap);
    logic [3:0] pat = 4'b0110;
    expq.delete();
    for (int k = 0; k < reps; k++) begin
      for (int b = PAT_W - 1; b >= 0; b--) expq.push_back(step_t'({pat[b], 1'b1, 1'b0}));
      if (parityBits() == 1) expq.push_back(step_t'({^pat, 1'b1, 1'b0}));
      if (k < reps - 1)
        for (int g = 0; g < gap; g++) expq.push_back(step_t'({1'b1, 1'b0, 1'b0}));
    end
    expq.push_back(step_t'({1'b1, 1'b0, 1'b1}));
  endfunction

  task automatic checkOutput(input string tag, input logic eo, input logic ev,
                             input logic ed, input logic eb);
    logic ao, av, ad, abz, ar;
    ao  = (sel != 0) ? out_b  : out_a;
    av  = (sel != 0) ? ov_b   : ov_a;
    ad  = (sel != 0) ? done_b : done_a;
    abz = (sel != 0) ? busy_b : busy_a;
    ar  = (sel != 0) ? rdy_b  : rdy_a;
    vectors++;
    assert (ao === eo) else begin
      miscompares++; $error("[TB] FAIL %s out observed=%b expected=%b", tag, ao, eo);
    end
    vectors++;
    assert (av === ev) else begin
      miscompares++; $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, av, ev);
    end
    vectors++;
    assert (ad === ed) else begin
      miscompares++; $error("[TB] FAIL %s done observed=%b expected=%b", tag, ad, ed);
    end
    vectors++;
    assert (abz === eb) else begin
      miscompares++; $error("[TB] FAIL %s busy observed=%b expected=%b", tag, abz, eb);
    end
    vectors++;
    assert (ar === !eb) else begin
      miscompares++; $error("[TB] FAIL %s start_ready observed=%b expected=%b", tag, ar, !eb);
    end
    if (av === 1'b1) begin
      det_sr = {det_sr[2:0], ao};
      det_n++;
      if (det_n >= 4 && det_sr == 4'b0110) det_hits++;
    end
  endtask

  task automatic setAbort(input logic v);
    if (sel != 0) ab_b = v; else ab_a = v;
  endtask

  task automatic applyStimulus(input int reps);
    if (sel != 0) begin sv_b = 1'b1; rc_b = 4'(reps); end
    else          begin sv_a = 1'b1; rc_a = 4'(reps); end
    @(posedge clk); #1;
    sv_a = 1'b0; sv_b = 1'b0;
    rc_a = 4'($urandom); rc_b = 4'($urandom);
  endtask

  // Walks the expected waveform; optionally aborts or resets after cycle abort_at / reset_at.
  task automatic checkQueue(input int reps, input int abort_at, input int reset_at);
    det_n = 0; det_hits = 0; det_sr = '0;
    buildBurst(reps, (sel != 0) ? GAP_B : GAP_A);
    for (int i = 0; i < expq.size(); i++) begin
      checkOutput($sformatf("r%0d_c%0d", reps, i + 1), expq[i].o, expq[i].v, expq[i].d, 1'b1);
      if (abort_at == i + 1) begin
        setAbort(1'b1);
        @(posedge clk); #1;
        setAbort(1'b0);
        checkOutput($sformatf("abort_r%0d_c%0d", reps, i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (reset_at == i + 1) begin
        #2 rst = 1'b1;
        #1 checkOutput("rst_async", 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          checkOutput($sformatf("post_rst_%0d", c), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        return;
      end
      @(posedge clk); #1;
    end
    checkOutput($sformatf("idle_after_r%0d", reps), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runBurst(input int reps, input int abort_at, input int reset_at);
    applyStimulus(reps);
    checkQueue(reps, abort_at, reset_at);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    sv_a = 1'b0; ab_a = 1'b0; rc_a = '0;
    sv_b = 1'b0; ab_b = 1'b0; rc_b = '0;
    det_n = 0; det_hits = 0; det_sr = '0;
    #12;
    sel = 0; checkOutput("reset_a", 1'b1, 1'b0, 1'b0, 1'b0);
    sel = 1; checkOutput("reset_b", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two repetitions with the default gap; valid-gated 0110 detector must fire twice.
    sel = 0;
    runBurst(2, 0, 0);
    vectors++;
    assert (det_hits === 2) else begin
      miscompares++; $error("[TB] FAIL detector_hits observed=%0d expected=%0d", det_hits, 2);
    end

    // Back-to-back repetitions with no gap.
    sel = 1;
    runBurst(3, 0, 0);

    sel = 0;
    runBurst(0, 0, 0);

    // Abort on the second gap cycle, then a fresh start right away.
    runBurst(4, PAT_W + parityBits() + 2, 0);
    runBurst(1, 0, 0);

    // Abort while idle has no effect.
    setAbort(1'b1);
    @(posedge clk); #1;
    setAbort(1'b0);
    checkOutput("abort_in_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during the second of three repetitions.
    runBurst(3, 0, PAT_W + parityBits() + GAP_A + 2);

    // start_valid held high: one burst, then re-accept as soon as ready returns.
    sv_a = 1'b1; rc_a = 4'd1;
    @(posedge clk); #1;
    checkQueue(1, 0, 0);
    @(posedge clk); #1;
    sv_a = 1'b0;
    checkQueue(1, 0, 0);

    // Randomised bursts on both instances, first one at the maximum count.
    for (int n = 0; n < 16; n++) begin
      sel = int'($urandom_range(0, 1));
      r   = (n == 0) ? 15 : int'($urandom_range(0, 15));
      len = burstLen(r, (sel != 0) ? GAP_B : GAP_A);
      ab  = 0;
      if (r > 0 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(1, len - 1));
      runBurst(r, ab, 0);
      vectors++;
      assert (expq.size() === len) else begin
        miscompares++; $error("[TB] FAIL model_len observed=%0d expected=%0d", expq.size(), len);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
